// File: rtl/fp_mul_if.sv
// Start/done handshake and operand/result bus of the sequential binary32 multiplier.
interface fp_mul_if;
    logic        i_valid;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic [31:0] o_result;

    modport master (
        output i_valid, i_a, i_b,
        input  o_valid, o_result
    );

    modport slave (
        input  i_valid, i_a, i_b,
        output o_valid, o_result
    );
endinterface

// File: rtl/fp_mul.sv
// Sequential binary32 multiplier: radix-2 shift-and-add mantissa product over
// 24 cycles, one normalize cycle, truncating result held until the next start.
module fp_mul (
    input  logic     i_clk,
    input  logic     i_rst_n,
    fp_mul_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [47:0] acc;
    logic [23:0] mcand;
    logic [23:0] mplier;
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        b_frac_nz;
    logic [31:0] result_q;

    logic        start;
    logic [24:0] add_sum;
    logic [47:0] acc_nxt;

    // Exponent arithmetic, normalization, truncation and special-case resolution.
    function automatic logic [31:0] norm_result(
        input logic        s,
        input logic [7:0]  xa,
        input logic [7:0]  xb,
        input logic        fa_nz,
        input logic        fb_nz,
        input logic [47:0] p
    );
        logic signed [9:0] e;
        logic [22:0]       frac;
        logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        nan_a  = (xa == 8'hFF) && fa_nz;
        nan_b  = (xb == 8'hFF) && fb_nz;
        inf_a  = (xa == 8'hFF) && !fa_nz;
        inf_b  = (xb == 8'hFF) && !fb_nz;
        zero_a = (xa == 8'h00);
        zero_b = (xb == 8'h00);
        e = $signed({2'b00, xa}) + $signed({2'b00, xb}) - 10'sd127;
        if (p[47]) begin
            frac = p[46:24];
            e    = e + 10'sd1;
        end else begin
            frac = p[45:23];
        end
        if (nan_a || nan_b)
            norm_result = 32'h7FC0_0000;
        else if ((inf_a && zero_b) || (inf_b && zero_a))
            norm_result = 32'h7FC0_0000;
        else if (inf_a || inf_b)
            norm_result = {s, 8'hFF, 23'd0};
        else if (zero_a || zero_b)
            norm_result = {s, 8'h00, 23'd0};
        else if (e >= 10'sd255)
            norm_result = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            norm_result = {s, 8'h00, 23'd0};
        else
            norm_result = {s, e[7:0], frac};
    endfunction

    assign start = bus.i_valid && ((state == IDLE) || (state == DONE));

    // One shift-and-add step: conditional add into the upper half, then shift {carry, acc} right.
    always_comb begin
        add_sum = {1'b0, acc[47:24]} + (mplier[0] ? {1'b0, mcand} : 25'd0);
        acc_nxt = {add_sum, acc[23:1]};
    end

    // Next-state logic; i_valid is ignored while an operation is in flight.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = bus.i_valid ? CALC : IDLE;
            CALC:    state_nxt = (cnt == 5'd23) ? NORM : CALC;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = bus.i_valid ? CALC : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Counter, accumulator and held result; reset abandons any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= 5'd0;
            acc      <= 48'd0;
            result_q <= 32'd0;
        end else if (start) begin
            cnt <= 5'd0;
            acc <= 48'd0;
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            acc <= acc_nxt;
        end else if (state == NORM) begin
            result_q <= norm_result(sign, ea, eb, (mcand[22:0] != 23'd0), b_frac_nz, acc);
        end
    end

    // Operand capture at start and multiplier shift during CALC.
    always_ff @(posedge i_clk) begin
        if (start) begin
            sign      <= bus.i_a[31] ^ bus.i_b[31];
            ea        <= bus.i_a[30:23];
            eb        <= bus.i_b[30:23];
            b_frac_nz <= (bus.i_b[22:0] != 23'd0);
            mcand     <= {1'b1, bus.i_a[22:0]};
            mplier    <= {1'b1, bus.i_b[22:0]};
        end else if (state == CALC) begin
            mplier <= {1'b0, mplier[23:1]};
        end
    end

    assign bus.o_valid  = (state == DONE);
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_fp_mul.sv
// Randomized and directed bench for fp_mul against a truncating binary32 model.
module tb_fp_mul;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    fp_mul_if bus ();

    fp_mul dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: real-valued mantissa product as an integer, truncated to 23 fraction bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          xa, xb, e;
        longint      ma, mb, p, frac;
        bit          nan_a, nan_b, inf_a, inf_b;
        s  = a[31] ^ b[31];
        xa = int'(a[30:23]);
        xb = int'(b[30:23]);
        nan_a = (xa == 255) && (a[22:0] != 0);
        nan_b = (xb == 255) && (b[22:0] != 0);
        inf_a = (xa == 255) && (a[22:0] == 0);
        inf_b = (xb == 255) && (b[22:0] == 0);
        if (nan_a || nan_b) return 32'h7FC0_0000;
        if ((inf_a && xb == 0) || (inf_b && xa == 0)) return 32'h7FC0_0000;
        if (inf_a || inf_b) return {s, 8'hFF, 23'd0};
        if (xa == 0 || xb == 0) return {s, 8'h00, 23'd0};
        ma = 64'h80_0000 + longint'(a[22:0]);
        mb = 64'h80_0000 + longint'(b[22:0]);
        p  = ma * mb;
        e  = xa + xb - 127;
        if (p >= (64'd1 << 47)) begin
            frac = (p / (64'd1 << 24)) % (64'd1 << 23);
            e    = e + 1;
        end else begin
            frac = (p / (64'd1 << 23)) % (64'd1 << 23);
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 8'h00, 23'd0};
        return {s, e[7:0], frac[22:0]};
    endfunction

    // Start one operation, optionally pulse i_valid again mid-CALC; report result,
    // latency in cycles and whether o_result held its previous value until done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                          output logic [31:0] res, output int lat, output bit held);
        logic [31:0] prev;
        @(negedge clk);
        prev        = bus.o_result;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        lat  = 0;
        held = 1'b1;
        if (bus.o_valid !== 1'b0) held = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.o_result !== prev) held = 1'b0;
            if (n == pulse_at) begin
                bus.i_a     = 32'h4110_0000;
                bus.i_b     = 32'h4110_0000;
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
        end
        bus.i_valid = 1'b0;
        res = bus.o_result;
    endtask

    logic [31:0] dir_a  [10] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h7F00_0000,
                                 32'h0080_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0001, 32'h3F80_0000};
    logic [31:0] dir_b  [10] = '{32'h4040_0000, 32'hBFC0_0000, 32'h3F80_0001, 32'h7F00_0000,
                                 32'h0080_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000,
                                 32'h3F80_0000, 32'hFF80_0000};
    // (-inf) x 2 = -inf; 1 x (-inf) = -inf.
    logic [31:0] dir_exp[10] = '{32'h40C0_0000, 32'hC010_0000, 32'h3F80_0002, 32'h7F80_0000,
                                 32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'hFF80_0000,
                                 32'h7FC0_0000, 32'hFF80_0000};

    initial begin
        logic [31:0] res, ra, rb;
        int          lat, pulses, run, max_run;
        bit          held, quiet;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_a     = 32'd0;
        bus.i_b     = 32'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_result", bus.o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", {31'd0, bus.o_valid}, 32'd0);

        // Directed operands, back-to-back starts from DONE.
        foreach (dir_a[i]) begin
            run_op(dir_a[i], dir_b[i], 0, res, lat, held);
            check($sformatf("dir%0d_res", i), res, dir_exp[i]);
            check($sformatf("dir%0d_lat", i), lat, 25);
            check($sformatf("dir%0d_hold", i), {31'd0, held}, 32'd1);
        end

        // Result stays put while DONE and i_valid is low.
        repeat (5) @(posedge clk);
        #1;
        check("done_valid", {31'd0, bus.o_valid}, 32'd1);
        check("done_stable", bus.o_result, 32'hFF80_0000);

        // i_valid pulsed mid-CALC is ignored.
        run_op(32'h4000_0000, 32'h4040_0000, 6, res, lat, held);
        check("pulse_res", res, 32'h40C0_0000);
        check("pulse_lat", lat, 25);

        // Asynchronous reset at CALC count 10.
        @(negedge clk);
        bus.i_a = 32'h3FC0_0000;
        bus.i_b = 32'h3FC0_0000;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("arst_result", bus.o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_valid !== 1'b0) quiet = 1'b0;
        end
        check("arst_quiet", {31'd0, quiet}, 32'd1);
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 0, res, lat, held);
        check("arst_restart", res, 32'h4010_0000);
        check("arst_lat", lat, 25);

        // i_valid held high: one-cycle o_valid pulses, each a correct result.
        @(negedge clk);
        bus.i_a = 32'h4000_0000;
        bus.i_b = 32'h4040_0000;
        bus.i_valid = 1'b1;
        pulses = 0; run = 0; max_run = 0;
        repeat (90) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) begin
                run++;
                if (run == 1) begin
                    pulses++;
                    check("held_res", bus.o_result, 32'h40C0_0000);
                end
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        bus.i_valid = 1'b0;
        check("held_width", max_run, 1);
        check("held_pulses", {31'd0, pulses >= 3}, 32'd1);
        quiet = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) begin
                quiet = 1'b1;
                break;
            end
        end
        check("held_settle", {31'd0, quiet}, 32'd1);

        // Random normal operands against the model.
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
            if (i % 2 == 0) rb = {$urandom_range(0, 1) == 1, 8'($urandom_range(64, 190)), 23'($urandom)};
            else            rb = {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op(ra, rb, 0, res, lat, held);
            check($sformatf("rnd%0d_res a=%h b=%h", i, ra, rb), res, ref_mul(ra, rb));
            check($sformatf("rnd%0d_lat", i), lat, 25);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
